feature_feeder: RTL

- Feature-side front end of the systolic array, directly upstream of the SA controller.
- Captures one input-feature tile from an upstream valid/ready stream into local storage (FILL), then replays it once per weight round while the controller holds its feature-read enable (SERVE).
- Drives the diagonally skewed per-row feature vector into the array and generates the controller's end-of-feature flag.

---
 rtl/feature_pkg.sv | 19 +
 rtl/feature_feeder_skew_line.sv | 35 +++
 rtl/feature_feeder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/feature_pkg.sv
// Shared types and helpers for the feature-side front end of the systolic array.
package feature_pkg;

    localparam int N_ROWS_ARRAY_DEF = 4;
    localparam int I_WIDTH_DEF      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        SERVE = 2'd2
    } feeder_state_t;

    typedef logic [N_ROWS_ARRAY_DEF-1:0][I_WIDTH_DEF-1:0] feature_word_t;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/feature_feeder_skew_line.sv
// Fixed-length delay line used to diagonally skew one feature row.
module skew_line #(
    parameter int WIDTH = 8,
    parameter int DELAY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DELAY == 0) begin : g_pass
            // Row 0 needs no extra stages; the control inputs are intentionally unused here.
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, rst_n, flush};
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DELAY];

            always_ff @(posedge clk) begin
                if (!rst_n || flush) begin
                    for (int i = 0; i < DELAY; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DELAY; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/feature_feeder.sv
// Captures one feature tile from a valid/ready stream, then replays it once per
// weight round as a diagonally skewed per-row vector for the systolic array.
module feature_feeder
    import feature_pkg::*;
#(
    parameter int N_ROWS_ARRAY             = 4,
    parameter int I_WIDTH                  = 8,
    parameter int INPUT_FEATURE_ADDR_WIDTH = 5,
    parameter int LEN_WIDTH                = INPUT_FEATURE_ADDR_WIDTH + 1
) (
    input  logic                              clk_i,
    input  logic                              general_rst_n_i,
    input  logic [LEN_WIDTH-1:0]              feature_len_i,
    input  logic                              start_fill_i,
    input  logic [N_ROWS_ARRAY*I_WIDTH-1:0]   s_data_i,
    input  logic                              s_valid_i,
    output logic                              s_ready_o,
    output logic                              fill_done_o,
    input  logic                              rd_feature_ld_i,
    output logic [I_WIDTH-1:0]                feature_row_o [0:N_ROWS_ARRAY-1],
    output logic [N_ROWS_ARRAY-1:0]           feature_valid_o,
    output logic                              end_feature_o
);

    localparam int                   DEPTH   = depth_of(INPUT_FEATURE_ADDR_WIDTH);
    localparam logic [LEN_WIDTH-1:0] DEPTH_L = LEN_WIDTH'(DEPTH);
    localparam logic [LEN_WIDTH-1:0] ONE_L   = LEN_WIDTH'(1);
    localparam int                   WORD_W  = N_ROWS_ARRAY * I_WIDTH;

    feeder_state_t        state, state_nxt;
    logic [LEN_WIDTH-1:0] wr_ptr, rd_ptr, len_q;
    logic [LEN_WIDTH-1:0] rd_ptr_inc, len_clamped;
    logic                 wr_en, rd_en, fill_complete, end_nxt;
    logic [WORD_W-1:0]    mem [DEPTH];
    logic [WORD_W-1:0]    base_data;
    logic                 base_valid;

    assign len_clamped = (feature_len_i > DEPTH_L) ? DEPTH_L : feature_len_i;
    assign rd_ptr_inc  = (rd_ptr < len_q) ? rd_ptr + ONE_L : rd_ptr;
    assign end_nxt     = (state == SERVE) && rd_feature_ld_i && !start_fill_i &&
                         (rd_ptr_inc == len_q);

    always_ff @(posedge clk_i) begin
        if (!general_rst_n_i) state <= IDLE;
        else                  state <= state_nxt;
    end

    // A start pulse restarts the fill from any state.
    always_comb begin
        state_nxt = state;
        if (start_fill_i) begin
            state_nxt = FILL;
        end else begin
            case (state)
                FILL:    if (fill_complete) state_nxt = SERVE;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        s_ready_o     = 1'b0;
        wr_en         = 1'b0;
        rd_en         = 1'b0;
        fill_complete = 1'b0;
        case (state)
            FILL: begin
                s_ready_o     = (wr_ptr < len_q);
                wr_en         = s_ready_o && s_valid_i && !start_fill_i;
                // Complete on the last write itself so fill_done follows it by one cycle.
                fill_complete = (wr_ptr == len_q) ||
                                (wr_en && ((wr_ptr + ONE_L) == len_q));
            end
            SERVE: rd_en = rd_feature_ld_i && (rd_ptr < len_q) && !start_fill_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!general_rst_n_i) begin
            {wr_ptr, rd_ptr, len_q} <= '0;
            fill_done_o             <= 1'b0;
            end_feature_o           <= 1'b0;
        end else begin
            end_feature_o <= end_nxt;
            if (start_fill_i) begin
                len_q       <= len_clamped;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                fill_done_o <= 1'b0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + ONE_L;
                if ((state == FILL) && fill_complete) fill_done_o <= 1'b1;
                // Dropping the read enable rewinds the tile for the next weight round.
                if ((state == SERVE) && rd_feature_ld_i) rd_ptr <= rd_ptr_inc;
                else                                     rd_ptr <= '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr[INPUT_FEATURE_ADDR_WIDTH-1:0]] <= s_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!general_rst_n_i) begin
            base_data  <= '0;
            base_valid <= 1'b0;
        end else begin
            base_valid <= rd_en;
            base_data  <= rd_en ? mem[rd_ptr[INPUT_FEATURE_ADDR_WIDTH-1:0]] : '0;
        end
    end

    generate
        for (genvar r = 0; r < N_ROWS_ARRAY; r++) begin : g_row
            logic [I_WIDTH:0] row_q;

            skew_line #(
                .WIDTH (I_WIDTH + 1),
                .DELAY (r)
            ) u_skew (
                .clk   (clk_i),
                .rst_n (general_rst_n_i),
                .flush (start_fill_i),
                .d     ({base_valid, base_data[r*I_WIDTH +: I_WIDTH]}),
                .q     (row_q)
            );

            assign feature_row_o[r]   = row_q[I_WIDTH-1:0];
            assign feature_valid_o[r] = row_q[I_WIDTH];
        end
    endgenerate

endmodule
